basilisc_2816_core: RTL and testbench

//  Minimal 8-bit CPU for a TinyTapeout tile: 8x8-bit register file, 16-bit PC, Z/S/C/V flags.
//  All memory (program and data) is external, reached over a fixed 4-cycle byte-serial bus on the pins.
//  Top of the tile: maps the TT pin set directly to the core.

---
 rtl/basilisc_2816_core_if.sv | 29 ++
 rtl/basilisc_2816_core.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_basilisc_2816_core.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/basilisc_2816_core_if.sv
// basilisc_2816_core_if: TinyTapeout pin bundle for the basilisc core.
// The core is the master (drives uo_out/uio_out/uio_oe). The memory or tile
// harness on the other side is the slave.
interface basilisc_2816_core_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );

  modport slave (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );
endinterface

// File: rtl/basilisc_2816_core.sv
// basilisc_2816_core: minimal 8-bit CPU for a TinyTapeout tile.
// The core has eight 8-bit registers, a 16-bit PC and Z/S/C/V flags.
// All program and data memory is external. It is reached over a fixed
// 4-cycle byte-serial bus (T0 addr lo + msg type, T1 addr hi, T2 write
// data, T3 read data sampled at the closing edge).
// Optional feature: define BASILISC_HALT_EN so that misc sub-op 100 halts
// the core. Without it, sub-op 100 is a NOP and uio_out[2] is tied to 0.
module basilisc_2816_core (
  input  logic                 clk,
  input  logic                 rst_n,
  basilisc_2816_core_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH0 = 3'd1;
  localparam logic [2:0] S_FETCH1 = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_EXEC   = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [1:0] MSG_IDLE  = 2'b00;
  localparam logic [1:0] MSG_READ  = 2'b01;
  localparam logic [1:0] MSG_WRITE = 2'b10;

  localparam logic [1:0] GRP_ALU_RR = 2'b00;
  localparam logic [1:0] GRP_ALU_RI = 2'b01;
  localparam logic [1:0] GRP_BRANCH = 2'b10;
  localparam logic [1:0] GRP_MISC   = 2'b11;

  localparam logic [2:0] SUB_LD     = 3'b000;
  localparam logic [2:0] SUB_ST     = 3'b001;
  localparam logic [2:0] SUB_CMP_RR = 3'b010;
  localparam logic [2:0] SUB_CMP_RI = 3'b011;
  localparam logic [2:0] SUB_HALT   = 3'b100;

  localparam logic [2:0] OP_MOV = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_ADC = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_SBC = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  logic [2:0]  state;
  logic [1:0]  tcyc;
  logic [15:0] pc;
  logic [7:0]  ir0;
  logic [7:0]  ir1;
  logic [7:0]  rdata;
  logic [7:0]  rf [8];
  logic        flag_z;
  logic        flag_s;
  logic        flag_c;
  logic        flag_v;

  // Instruction fields
  logic [1:0]  grp;
  logic [2:0]  op;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [1:0]  pair;
  logic        is_ld;
  logic        is_st;
  logic        is_cmp;
  logic        halt_req;
  logic        halted;

  assign grp    = ir0[7:6];
  assign op     = ir0[5:3];
  assign rd     = ir0[2:0];
  assign rs     = ir1[2:0];
  assign pair   = ir1[2:1];
  assign is_ld  = (grp == GRP_MISC) && (op == SUB_LD);
  assign is_st  = (grp == GRP_MISC) && (op == SUB_ST);
  assign is_cmp = (grp == GRP_MISC) && ((op == SUB_CMP_RR) || (op == SUB_CMP_RI));

`ifdef BASILISC_HALT_EN
  assign halt_req = (grp == GRP_MISC) && (op == SUB_HALT);
  assign halted   = (state == S_HALT);
`else
  assign halt_req = 1'b0;
  assign halted   = 1'b0;
`endif

  // The tile enable and the bidirectional inputs are not used by the core.
  logic unused_pins;
  assign unused_pins = ^{bus.ena, bus.uio_in};

  // Bus address and phase decode
  logic        bus_active;
  logic        bus_write;
  logic [15:0] bus_addr;
  logic [15:0] mem_addr;
  logic [7:0]  uo_val;
  logic [1:0]  msg;

  // A pair is named by its high register; the low byte sits in the next index.
  assign mem_addr   = {rf[{pair, 1'b0}], rf[{pair, 1'b1}]};
  assign bus_active = (state == S_FETCH0) || (state == S_FETCH1) || (state == S_MEM);
  assign bus_write  = (state == S_MEM) && is_st;

  // Select the address presented on the current transaction
  always_comb begin
    bus_addr = '0;
    case (state)
      S_FETCH0: bus_addr = pc;
      S_FETCH1: bus_addr = pc + 16'd1;
      S_MEM:    bus_addr = mem_addr;
      default:  bus_addr = '0;
    endcase
  end

  // Drive the byte lane according to the bus phase
  always_comb begin
    uo_val = '0;
    if (bus_active) begin
      case (tcyc)
        2'd0:    uo_val = bus_addr[7:0];
        2'd1:    uo_val = bus_addr[15:8];
        2'd2:    uo_val = bus_write ? rf[rd] : 8'h00;
        default: uo_val = '0;
      endcase
    end
  end

  assign msg = (bus_active && (tcyc == 2'd0)) ? (bus_write ? MSG_WRITE : MSG_READ) : MSG_IDLE;

  assign bus.uo_out  = uo_val;
  assign bus.uio_out = {5'b00000, halted, msg};
  assign bus.uio_oe  = 8'h07;

  // ALU
  logic [2:0] alu_op;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_res;
  logic [8:0] alu_wide;
  logic       alu_c;
  logic       alu_v;
  logic       alu_wb;
  logic       flags_wb;
  logic       ld_wb;

  assign alu_op   = (grp == GRP_MISC) ? OP_SUB : op;
  assign alu_a    = rf[rd];
  assign alu_b    = ((grp == GRP_ALU_RR) || ((grp == GRP_MISC) && (op == SUB_CMP_RR))) ? rf[rs] : ir1;
  assign alu_wb   = (grp == GRP_ALU_RR) || (grp == GRP_ALU_RI);
  assign flags_wb = (alu_wb && (op != OP_MOV)) || is_cmp;
  assign ld_wb    = is_ld;

  // Combinational result and flags for the decoded operation
  always_comb begin
    alu_wide = '0;
    alu_res  = alu_b;
    alu_c    = flag_c;
    alu_v    = flag_v;
    case (alu_op)
      OP_MOV: alu_res = alu_b;
      OP_ADD, OP_ADC: begin
        alu_wide = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, (alu_op == OP_ADC) & flag_c};
        alu_res  = alu_wide[7:0];
        alu_c    = alu_wide[8];
        alu_v    = (alu_a[7] == alu_b[7]) && (alu_res[7] != alu_a[7]);
      end
      OP_SUB, OP_SBC: begin
        // Bit 8 of the 9-bit difference is the borrow-out.
        alu_wide = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, (alu_op == OP_SBC) & flag_c};
        alu_res  = alu_wide[7:0];
        alu_c    = alu_wide[8];
        alu_v    = (alu_a[7] != alu_b[7]) && (alu_res[7] != alu_a[7]);
      end
      OP_AND: begin
        alu_res = alu_a & alu_b;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
      OP_OR: begin
        alu_res = alu_a | alu_b;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
      OP_XOR: begin
        alu_res = alu_a ^ alu_b;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
      end
      default: alu_res = alu_b;
    endcase
  end

  // Branch condition and next PC
  logic        cond_even;
  logic        taken;
  logic [15:0] pc_next;

  // Evaluate the even condition codes; odd codes are their inverse
  always_comb begin
    cond_even = 1'b1;
    case (ir0[3:1])
      3'd0:    cond_even = 1'b1;
      3'd1:    cond_even = flag_z;
      3'd2:    cond_even = flag_s;
      3'd3:    cond_even = flag_c;
      3'd4:    cond_even = !flag_c && !flag_z;
      3'd5:    cond_even = flag_v;
      3'd6:    cond_even = !flag_z && (flag_s == flag_v);
      default: cond_even = (flag_s != flag_v);
    endcase
  end

  assign taken   = (grp == GRP_BRANCH) && (cond_even ^ ir0[0]);
  assign pc_next = taken ? (pc + 16'd2 + {{8{ir1[7]}}, ir1}) : (pc + 16'd2);

  // Sequencer: idle slot, fetch b0, fetch b1, optional data transfer, execute
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      tcyc  <= '0;
      pc    <= '0;
      ir0   <= '0;
      ir1   <= '0;
      rdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_FETCH0;
          tcyc  <= '0;
        end
        S_FETCH0: begin
          tcyc <= tcyc + 2'd1;
          if (tcyc == 2'd3) begin
            ir0   <= bus.ui_in;
            state <= S_FETCH1;
          end
        end
        S_FETCH1: begin
          tcyc <= tcyc + 2'd1;
          if (tcyc == 2'd3) begin
            ir1   <= bus.ui_in;
            state <= (is_ld || is_st) ? S_MEM : S_EXEC;
          end
        end
        S_MEM: begin
          tcyc <= tcyc + 2'd1;
          if (tcyc == 2'd3) begin
            rdata <= bus.ui_in;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          pc    <= pc_next;
          tcyc  <= '0;
          state <= halt_req ? S_HALT : S_FETCH0;
        end
        S_HALT: state <= S_HALT;
        default: begin
          state <= S_IDLE;
          tcyc  <= '0;
        end
      endcase
    end
  end

  // Register file writeback in the execute cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 8; i++) rf[i] <= '0;
    end else if (state == S_EXEC) begin
      if (alu_wb) begin
        rf[rd] <= alu_res;
      end else if (ld_wb) begin
        rf[rd] <= rdata;
      end
    end
  end

  // Flag update in the execute cycle (MOV and non-ALU instructions keep flags)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_s <= 1'b0;
      flag_c <= 1'b0;
      flag_v <= 1'b0;
    end else if ((state == S_EXEC) && flags_wb) begin
      flag_z <= (alu_res == 8'h00);
      flag_s <= alu_res[7];
      flag_c <= alu_c;
      flag_v <= alu_v;
    end
  end

endmodule

// File: tb/tb_basilisc_2816_core.sv
// tb_basilisc_2816_core: scoreboard bench for basilisc_2816_core.
// An instruction-level reference model predicts every bus transaction as
// (type, address, write data, start cycle) into a queue. A bus monitor
// plays the memory and compares each completed transaction with the queue.
module tb_basilisc_2816_core;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  basilisc_2816_core_if bus ();
  basilisc_2816_core dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    int kind;
    int addr;
    int data;
    int cyc;
  } txn_t;

  txn_t exp_q[$];
  txn_t e;
  int n_checks = 0;
  int n_fail = 0;
  int cyc;
  int n_txn = 0;
  logic [7:0] dut_mem [65536];
  logic [7:0] ref_mem [65536];

  // reference model state
  int rr [8];
  bit fz, fs, fc, fv;
  int mpc, mcyc, halt_cyc;
  bit m_halted;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Bus monitor / memory slave
  int ph;
  bit active;
  int t_kind, t_data, t_cyc;
  logic [15:0] t_addr;

  always @(negedge clk) begin
    if (!rst_n) begin
      active = 1'b0;
      ph = 0;
    end else if (active) begin
      check("type_only_in_t0", int'(bus.uio_out[1:0]), 0);
      case (ph)
        1: begin
          t_addr[15:8] = bus.uo_out;
          if (t_kind == 1) bus.ui_in = dut_mem[t_addr];
        end
        2: begin
          if (t_kind == 2) begin
            t_data = int'(bus.uo_out);
            dut_mem[t_addr] = bus.uo_out;
          end
        end
        default: begin
          check("t3_uo_zero", int'(bus.uo_out), 0);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if (e.kind != t_kind || e.addr != int'(t_addr) || (t_kind == 2 && e.data != t_data) || e.cyc != t_cyc) begin
              n_fail++;
              $display("FAIL bus_txn: got kind=%0d addr=%04h data=%02h cyc=%0d, expected kind=%0d addr=%04h data=%02h cyc=%0d",
                       t_kind, t_addr, t_data, t_cyc, e.kind, e.addr, e.data, e.cyc);
            end
          end
          active = 1'b0;
        end
      endcase
      ph++;
    end else if (bus.uio_out[1:0] != 2'b00) begin
      active = 1'b1;
      ph = 1;
      t_kind = int'(bus.uio_out[1:0]);
      t_addr[7:0] = bus.uo_out;
      t_data = 0;
      t_cyc = cyc;
      n_txn++;
    end else begin
      check("idle_uo_zero", int'(bus.uo_out), 0);
    end
  end

  // ---------------- reference model ----------------
  function automatic void push(input int kind, input int addr, input int data, input int c);
    txn_t t;
    t.kind = kind;
    t.addr = addr;
    t.data = data;
    t.cyc = c;
    exp_q.push_back(t);
  endfunction

  function automatic int sgn(input int x);
    return (x > 127) ? x - 256 : x;
  endfunction

  function automatic void m_alu(input int op, input int rd, input int b, input bit wb);
    int a, full, sres, res, cin;
    a = rr[rd];
    res = 0;
    cin = fc ? 1 : 0;
    case (op)
      0: begin
        if (wb) rr[rd] = b;
        return;
      end
      1, 2: begin
        if (op == 1) cin = 0;
        full = a + b + cin;
        sres = sgn(a) + sgn(b) + cin;
        fc = (full > 255);
        fv = (sres > 127) || (sres < -128);
        res = full % 256;
      end
      3, 4: begin
        if (op == 3) cin = 0;
        full = a - b - cin;
        sres = sgn(a) - sgn(b) - cin;
        fc = (full < 0);
        fv = (sres > 127) || (sres < -128);
        res = (full + 256) % 256;
      end
      5: begin res = a & b; fc = 0; fv = 0; end
      6: begin res = a | b; fc = 0; fv = 0; end
      default: begin res = a ^ b; fc = 0; fv = 0; end
    endcase
    fz = (res == 0);
    fs = (res > 127);
    if (wb) rr[rd] = res;
  endfunction

  function automatic bit m_cond(input int cc);
    bit t;
    case (cc / 2)
      0: t = 1'b1;
      1: t = fz;
      2: t = fs;
      3: t = fc;
      4: t = !fc && !fz;
      5: t = fv;
      6: t = !fz && (fs == fv);
      default: t = (fs != fv);
    endcase
    return (cc % 2 == 1) ? !t : t;
  endfunction

  function automatic void m_step();
    int b0, b1, npc, grp, op, r, p, addr;
    push(1, mpc, 0, mcyc);
    b0 = int'(ref_mem[mpc]);
    mcyc += 4;
    push(1, (mpc + 1) % 65536, 0, mcyc);
    b1 = int'(ref_mem[(mpc + 1) % 65536]);
    mcyc += 4;
    npc = (mpc + 2) % 65536;
    grp = b0 / 64;
    op = (b0 / 8) % 8;
    r = b0 % 8;
    p = (b1 / 2) % 4;
    addr = rr[2 * p] * 256 + rr[2 * p + 1];
    case (grp)
      0: m_alu(op, r, rr[b1 % 8], 1'b1);
      1: m_alu(op, r, b1, 1'b1);
      2: if (m_cond(b0 % 16)) npc = (mpc + 2 + sgn(b1) + 65536) % 65536;
      default: begin
        case (op)
          0: begin
            push(1, addr, 0, mcyc);
            mcyc += 4;
            rr[r] = int'(ref_mem[addr]);
          end
          1: begin
            push(2, addr, rr[r], mcyc);
            ref_mem[addr] = 8'(rr[r]);
            mcyc += 4;
          end
          2: m_alu(3, r, rr[b1 % 8], 1'b0);
          3: m_alu(3, r, b1, 1'b0);
`ifdef BASILISC_HALT_EN
          4: m_halted = 1'b1;
`endif
          default: ;
        endcase
      end
    endcase
    mcyc += 1;
    mpc = npc;
    if (m_halted) halt_cyc = mcyc;
  endfunction

  // ---------------- stimulus ----------------
  function automatic void put(input int a, input int b0, input int b1);
    dut_mem[a] = 8'(b0);
    dut_mem[(a + 1) % 65536] = 8'(b1);
  endfunction

  function automatic void clear_mem();
    for (int i = 0; i < 65536; i++) dut_mem[i] = 8'h00;
  endfunction

  task automatic episode(input int n_instr);
    int n0;
    rst_n = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 65536; i++) ref_mem[i] = dut_mem[i];
    for (int i = 0; i < 8; i++) rr[i] = 0;
    fz = 0; fs = 0; fc = 0; fv = 0;
    mpc = 0; mcyc = 1; m_halted = 0; halt_cyc = 0;
    for (int k = 0; k < n_instr && !m_halted; k++) m_step();
    repeat (2) @(negedge clk);
    #2;
    check("rst_uo_out", int'(bus.uo_out), 0);
    check("rst_uio_out", int'(bus.uio_out), 0);
    check("rst_uio_oe", int'(bus.uio_oe), 8'h07);
    rst_n = 1'b1;
    #1 check("post_rst_uio_out", int'(bus.uio_out), 0);
    for (int k = 0; k < n_instr * 14 + 50 && exp_q.size() != 0; k++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    if (m_halted) begin
      for (int k = 0; k < 64 && cyc < halt_cyc; k++) @(negedge clk);
      #1 check("halted_flag", int'(bus.uio_out[2]), 1);
      n0 = n_txn;
      repeat (40) @(negedge clk);
      #1 check("halt_bus_quiet", n_txn - n0, 0);
      check("halt_flag_held", int'(bus.uio_out[2]), 1);
    end else begin
      @(negedge clk);
      #1 check("not_halted", int'(bus.uio_out[2]), 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.ena = 1'b1;
    bus.uio_in = 8'h00;
    bus.ui_in = 8'h00;

    // Directed: flags, branches, store/load through register pairs.
    clear_mem();
    put(16'h0000, 8'h45, 8'h05);
    put(16'h0002, 8'h4D, 8'hFB);
    put(16'h0004, 8'h82, 8'h02);
    put(16'h0006, 8'h80, 8'hFE);
    put(16'h0008, 8'h41, 8'h7F);
    put(16'h000A, 8'h49, 8'h01);
    put(16'h000C, 8'h8A, 8'h02);
    put(16'h000E, 8'h80, 8'hFE);
    put(16'h0010, 8'h42, 8'h03);
    put(16'h0012, 8'hDA, 8'h05);
    put(16'h0014, 8'h87, 8'hFE);
    put(16'h0016, 8'h86, 8'h02);
    put(16'h0018, 8'h80, 8'hFE);
    put(16'h001A, 8'h40, 8'h12);
    put(16'h001C, 8'h41, 8'h34);
    put(16'h001E, 8'h43, 8'hA5);
    put(16'h0020, 8'hCB, 8'h00);
    put(16'h0022, 8'hC4, 8'h02);
    put(16'h0024, 8'hCC, 8'h00);
    put(16'h0026, 8'hE0, 8'h00);
    put(16'h0028, 8'h80, 8'hFE);
    dut_mem[16'h03A5] = 8'h5A;
    episode(25);

    // Directed: branch backwards past zero, fetch straddling FFFF->0000,
    // store over the program's own first byte.
    clear_mem();
    put(16'h0000, 8'h80, 8'h80);
    put(16'hFF82, 8'h80, 8'h7B);
    dut_mem[16'hFFFF] = 8'hC9;
    episode(20);

    // Randomized programs and data.
    for (int ep = 0; ep < 3; ep++) begin
      for (int i = 0; i < 65536; i++) dut_mem[i] = 8'($urandom);
      episode(120);
    end

    // Hand-checked store pins, then reset mid-transaction.
    clear_mem();
    put(16'h0000, 8'h40, 8'h12);
    put(16'h0002, 8'h41, 8'h34);
    put(16'h0004, 8'h43, 8'hA5);
    put(16'h0006, 8'hCB, 8'h00);
    exp_q.delete();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("first_fetch_type", int'(bus.uio_out[1:0]), 1);
    check("first_fetch_lo", int'(bus.uo_out), 0);
    for (int k = 0; k < 100 && cyc != 36; k++) @(negedge clk);
    check("st_t0_type", int'(bus.uio_out[1:0]), 2);
    check("st_t0_lo", int'(bus.uo_out), 8'h34);
    @(negedge clk);
    check("st_t1_hi", int'(bus.uo_out), 8'h12);
    @(negedge clk);
    check("st_t2_data", int'(bus.uo_out), 8'hA5);
    #2 rst_n = 1'b0;
    #1 check("abort_uo_out", int'(bus.uo_out), 0);
    check("abort_uio_out", int'(bus.uio_out), 0);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
